// File: rtl/lift_call_scheduler_if.sv
// Request/status bundle between the call panels, the scheduler and the display/motor layer.
// The master drives the button requests; the slave (scheduler) drives the car status.
interface lift_call_scheduler_if #(
  parameter int N_FLOORS = 8,
  parameter int FLOOR_W  = 3
);
  logic                cab_valid;
  logic [FLOOR_W-1:0]  cab_floor;
  logic                hall_valid;
  logic [FLOOR_W-1:0]  hall_floor;
  logic [FLOOR_W-1:0]  car_floor_o;
  logic [1:0]          dir_o;
  logic                moving_o;
  logic                door_open_o;
  logic                busy_o;
  logic [N_FLOORS-1:0] pending_o;

  modport master (
    output cab_valid, cab_floor, hall_valid, hall_floor,
    input  car_floor_o, dir_o, moving_o, door_open_o, busy_o, pending_o
  );

  modport slave (
    input  cab_valid, cab_floor, hall_valid, hall_floor,
    output car_floor_o, dir_o, moving_o, door_open_o, busy_o, pending_o
  );
endinterface

// File: rtl/lift_call_scheduler.sv
// Collective (SCAN) call scheduler for a single lift car: latches calls, picks direction,
// steps the car floor by floor and holds the door for a fixed dwell.
module lift_call_scheduler #(
  parameter int N_FLOORS   = 8,
  parameter int FLOOR_W    = 3,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  lift_call_scheduler_if.slave  bus
);

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;
  localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
  localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYC - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYC - 1);
  localparam logic [N_FLOORS-1:0] BIT0  = N_FLOORS'(1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MOVE = 2'd1, ST_DOOR = 2'd2} state_t;

  state_t              r_state,   w_state_nxt;
  logic [N_FLOORS-1:0] r_pending, w_pending_nxt, w_set, w_clr;
  logic [FLOOR_W-1:0]  r_floor,   w_floor_nxt, w_step_floor;
  logic [1:0]          r_dir,     w_dir_nxt, w_pick;
  logic [TW-1:0]       r_travel,  w_travel_nxt;
  logic [DW-1:0]       r_dwell,   w_dwell_nxt;
  logic                r_moving, r_door, r_busy;
  logic                w_here, w_above, w_below, w_arrive_hit, w_ahead_of_step;
  logic                w_cab_absorb, w_hall_absorb;

  function automatic logic f_any_above(input logic [N_FLOORS-1:0] pend, input logic [FLOOR_W-1:0] fl);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) r = r | (pend[i] & (i > int'(fl)));
    return r;
  endfunction

  function automatic logic f_any_below(input logic [N_FLOORS-1:0] pend, input logic [FLOOR_W-1:0] fl);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) r = r | (pend[i] & (i < int'(fl)));
    return r;
  endfunction

  // Nearest pending floor wins; N_FLOORS acts as "no call on this side", equal distance goes up.
  function automatic logic [1:0] f_pick_dir(input logic [N_FLOORS-1:0] pend, input logic [FLOOR_W-1:0] fl);
    int d_up;
    int d_dn;
    d_up = N_FLOORS;
    d_dn = N_FLOORS;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pend[i] && (i > int'(fl)) && ((i - int'(fl)) < d_up)) d_up = i - int'(fl);
      else if (pend[i] && (i < int'(fl)) && ((int'(fl) - i) < d_dn)) d_dn = int'(fl) - i;
      else d_up = d_up;
    end
    if ((d_up == N_FLOORS) && (d_dn == N_FLOORS)) return DIR_NONE;
    else if (d_up <= d_dn) return DIR_UP;
    else return DIR_DN;
  endfunction

  assign w_here          = r_pending[r_floor];
  assign w_above         = f_any_above(r_pending, r_floor);
  assign w_below         = f_any_below(r_pending, r_floor);
  assign w_pick          = f_pick_dir(r_pending, r_floor);
  assign w_step_floor    = (r_dir == DIR_DN) ? (r_floor - FLOOR_W'(1)) : (r_floor + FLOOR_W'(1));
  assign w_ahead_of_step = (r_dir == DIR_DN) ? f_any_below(r_pending, w_step_floor)
                                             : f_any_above(r_pending, w_step_floor);
  assign w_cab_absorb    = (r_state == ST_DOOR) && (bus.cab_floor == r_floor);
  assign w_hall_absorb   = (r_state == ST_DOOR) && (bus.hall_floor == r_floor);

  // Request capture mask and next-floor hit (out-of-range floors match no bit).
  always_comb begin
    w_set        = '0;
    w_arrive_hit = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      w_set[i] = (bus.cab_valid  && (int'(bus.cab_floor)  == i) && !w_cab_absorb) ||
                 (bus.hall_valid && (int'(bus.hall_floor) == i) && !w_hall_absorb);
      w_arrive_hit = w_arrive_hit | (r_pending[i] & (int'(w_step_floor) == i));
    end
  end

  // Next-state, motion and timer decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_floor_nxt  = r_floor;
    w_dir_nxt    = r_dir;
    w_travel_nxt = r_travel;
    w_dwell_nxt  = r_dwell;
    w_clr        = '0;
    case (r_state)
      ST_IDLE: begin
        w_dir_nxt    = DIR_NONE;
        w_travel_nxt = '0;
        w_dwell_nxt  = '0;
        if (w_here) begin
          w_state_nxt = ST_DOOR;
          w_clr       = BIT0 << r_floor;
        end else if (w_pick != DIR_NONE) begin
          w_state_nxt = ST_MOVE;
          w_dir_nxt   = w_pick;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (r_travel == TRAVEL_LAST) begin
          w_travel_nxt = '0;
          w_floor_nxt  = w_step_floor;
          if (w_arrive_hit) begin
            w_state_nxt = ST_DOOR;
            w_dwell_nxt = '0;
            w_clr       = BIT0 << w_step_floor;
          end else if (w_ahead_of_step) begin
            w_state_nxt = ST_MOVE;
          end else begin
            w_state_nxt = ST_IDLE;
            w_dir_nxt   = DIR_NONE;
          end
        end else begin
          w_travel_nxt = r_travel + TW'(1);
        end
      end
      ST_DOOR: begin
        if (r_dwell == DOOR_LAST) begin
          w_dwell_nxt  = '0;
          w_travel_nxt = '0;
          if (((r_dir == DIR_UP) && w_above) || ((r_dir == DIR_DN) && w_below)) begin
            w_state_nxt = ST_MOVE;
          end else if ((r_dir == DIR_UP) && w_below) begin
            w_state_nxt = ST_MOVE;
            w_dir_nxt   = DIR_DN;
          end else if ((r_dir == DIR_DN) && w_above) begin
            w_state_nxt = ST_MOVE;
            w_dir_nxt   = DIR_UP;
          end else if ((r_dir == DIR_NONE) && (w_pick != DIR_NONE)) begin
            w_state_nxt = ST_MOVE;
            w_dir_nxt   = w_pick;
          end else if (w_here) begin
            w_state_nxt = ST_DOOR;
            w_clr       = BIT0 << r_floor;
          end else begin
            w_state_nxt = ST_IDLE;
            w_dir_nxt   = DIR_NONE;
          end
        end else begin
          w_dwell_nxt = r_dwell + DW'(1);
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_dir_nxt    = DIR_NONE;
        w_travel_nxt = '0;
        w_dwell_nxt  = '0;
      end
    endcase
    w_pending_nxt = (r_pending | w_set) & ~w_clr;
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_floor   <= '0;
      r_dir     <= DIR_NONE;
      r_travel  <= '0;
      r_dwell   <= '0;
      r_moving  <= 1'b0;
      r_door    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_floor   <= w_floor_nxt;
      r_dir     <= w_dir_nxt;
      r_travel  <= w_travel_nxt;
      r_dwell   <= w_dwell_nxt;
      r_moving  <= (w_state_nxt == ST_MOVE);
      r_door    <= (w_state_nxt == ST_DOOR);
      r_busy    <= (w_state_nxt != ST_IDLE) | (|w_pending_nxt);
    end
  end

  assign bus.car_floor_o = r_floor;
  assign bus.dir_o       = r_dir;
  assign bus.moving_o    = r_moving;
  assign bus.door_open_o = r_door;
  assign bus.busy_o      = r_busy;
  assign bus.pending_o   = r_pending;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler: hand-computed SCAN journeys, dwell, absorb,
// out-of-range floors on a 6-floor instance and asynchronous reset mid-travel.
module tb_lift_call_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  lift_call_scheduler_if #(.N_FLOORS(8), .FLOOR_W(3)) bus8 ();
  lift_call_scheduler_if #(.N_FLOORS(6), .FLOOR_W(3)) bus6 ();

  lift_call_scheduler #(.N_FLOORS(8), .FLOOR_W(3), .TRAVEL_CYC(4), .DOOR_CYC(6)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  lift_call_scheduler #(.N_FLOORS(6), .FLOOR_W(3), .TRAVEL_CYC(4), .DOOR_CYC(6)) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input logic cv, input int cf, input logic hv, input int hf);
    bus8.cab_valid  = cv;
    bus8.cab_floor  = 3'(cf);
    bus8.hall_valid = hv;
    bus8.hall_floor = 3'(hf);
    tick();
    bus8.cab_valid  = 1'b0;
    bus8.hall_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus8.cab_valid = 1'b0; bus8.hall_valid = 1'b0;
    bus8.cab_floor = 3'd0; bus8.hall_floor = 3'd0;
    tick();
    tick();
    check({tag, "_rst_floor"}, 32'(bus8.car_floor_o), 32'd0);
    check({tag, "_rst_pend"},  32'(bus8.pending_o),   32'd0);
    check({tag, "_rst_busy"},  32'(bus8.busy_o),      32'd0);
    check({tag, "_rst_dir"},   32'(bus8.dir_o),       32'd0);
    rst = 1'b0;
    tick();
  endtask

  // Wait for the door to open, then check the stop and the dwell length.
  task automatic serve(input string tag, input int fl, input int dir);
    int k;
    int cnt;
    k = 0;
    while ((bus8.door_open_o !== 1'b1) && (k < 200)) begin
      tick();
      k++;
    end
    check({tag, "_door_reached"}, 32'(bus8.door_open_o), 32'd1);
    check({tag, "_floor"}, 32'(bus8.car_floor_o), 32'(fl));
    check({tag, "_dir"},   32'(bus8.dir_o), 32'(dir));
    check({tag, "_bitclr"}, 32'(bus8.pending_o[fl]), 32'd0);
    cnt = 0;
    k = 0;
    while ((bus8.door_open_o === 1'b1) && (k < 50)) begin
      cnt++;
      tick();
      k++;
    end
    check({tag, "_dwell"}, 32'(cnt), 32'd6);
  endtask

  task automatic wait_moving_at(input string tag, input int fl);
    int k;
    k = 0;
    while (!((bus8.car_floor_o == 3'(fl)) && (bus8.moving_o === 1'b1)) && (k < 100)) begin
      tick();
      k++;
    end
    check({tag, "_moving_at"}, 32'(bus8.car_floor_o), 32'(fl));
    check({tag, "_moving"}, 32'(bus8.moving_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    bus6.cab_valid = 1'b0; bus6.hall_valid = 1'b0;
    bus6.cab_floor = 3'd0; bus6.hall_floor = 3'd0;

    // Single cab call to 3: timing of capture, departure, floor steps, dwell.
    do_reset("t1");
    press(1'b1, 3, 1'b0, 0);
    check("t1_pend", 32'(bus8.pending_o), 32'h08);
    check("t1_dir_before", 32'(bus8.dir_o), 32'd0);
    check("t1_busy", 32'(bus8.busy_o), 32'd1);
    tick();
    check("t1_dir_up", 32'(bus8.dir_o), 32'd1);
    check("t1_moving", 32'(bus8.moving_o), 32'd1);
    repeat (3) tick();
    check("t1_floor0", 32'(bus8.car_floor_o), 32'd0);
    tick();
    check("t1_floor1", 32'(bus8.car_floor_o), 32'd1);
    repeat (4) tick();
    check("t1_floor2", 32'(bus8.car_floor_o), 32'd2);
    repeat (4) tick();
    check("t1_floor3", 32'(bus8.car_floor_o), 32'd3);
    check("t1_door_now", 32'(bus8.door_open_o), 32'd1);
    check("t1_pend_clr", 32'(bus8.pending_o), 32'h00);
    serve("t1", 3, 1);
    check("t1_idle_busy", 32'(bus8.busy_o), 32'd0);
    check("t1_idle_dir", 32'(bus8.dir_o), 32'd0);

    // Idle at 3, cab 3: door opens in place; a repeat press while open is absorbed.
    press(1'b1, 3, 1'b0, 0);
    check("t3_pend", 32'(bus8.pending_o), 32'h08);
    tick();
    check("t3_door", 32'(bus8.door_open_o), 32'd1);
    check("t3_pend_clr", 32'(bus8.pending_o), 32'h00);
    check("t3_moving", 32'(bus8.moving_o), 32'd0);
    cnt = 1;
    for (int k = 0; k < 20; k++) begin
      bus8.cab_valid = (k == 1);
      bus8.cab_floor = 3'd3;
      tick();
      if (bus8.door_open_o === 1'b1) cnt++;
      else break;
    end
    bus8.cab_valid = 1'b0;
    check("t3_dwell", 32'(cnt), 32'd6);
    check("t3_absorbed", 32'(bus8.pending_o), 32'h00);
    check("t3_floor", 32'(bus8.car_floor_o), 32'd3);
    check("t3_busy", 32'(bus8.busy_o), 32'd0);

    // Collective run: 5 up, hall 2 and 0 picked up on the way, reversal to 0 last.
    do_reset("t2");
    press(1'b1, 5, 1'b0, 0);
    wait_moving_at("t2", 1);
    press(1'b0, 0, 1'b1, 2);
    press(1'b0, 0, 1'b1, 0);
    check("t2_pend", 32'(bus8.pending_o), 32'h25);
    serve("t2a", 2, 1);
    serve("t2b", 5, 1);
    check("t2_reverse_dir", 32'(bus8.dir_o), 32'd2);
    check("t2_reverse_moving", 32'(bus8.moving_o), 32'd1);
    serve("t2c", 0, 2);
    check("t2_busy", 32'(bus8.busy_o), 32'd0);

    // Parked at 4: calls 2 and 7 -> nearer 2 first; calls 2 and 6 -> tie goes up.
    do_reset("t4");
    press(1'b1, 4, 1'b0, 0);
    serve("t4p", 4, 1);
    press(1'b1, 7, 1'b1, 2);
    check("t4_pend", 32'(bus8.pending_o), 32'h84);
    tick();
    check("t4_dir_down", 32'(bus8.dir_o), 32'd2);
    serve("t4a", 2, 2);
    serve("t4b", 7, 1);
    press(1'b1, 4, 1'b0, 0);
    serve("t4q", 4, 2);
    press(1'b1, 6, 1'b1, 2);
    check("t4_pend_tie", 32'(bus8.pending_o), 32'h44);
    tick();
    check("t4_dir_tie", 32'(bus8.dir_o), 32'd1);
    serve("t4c", 6, 1);
    serve("t4d", 2, 2);

    // Cab and hall on the same floor collapse to one stop.
    press(1'b1, 6, 1'b1, 6);
    check("t5_pend", 32'(bus8.pending_o), 32'h40);
    serve("t5", 6, 1);
    repeat (10) tick();
    check("t5_no_second_stop", 32'(bus8.door_open_o), 32'd0);
    check("t5_busy", 32'(bus8.busy_o), 32'd0);

    // Six-floor instance ignores floors 7 and 6.
    bus6.cab_valid = 1'b1; bus6.cab_floor = 3'd7;
    bus6.hall_valid = 1'b1; bus6.hall_floor = 3'd6;
    tick();
    bus6.cab_valid = 1'b0; bus6.hall_valid = 1'b0;
    check("t6_pend", 32'(bus6.pending_o), 32'h00);
    check("t6_busy", 32'(bus6.busy_o), 32'd0);
    tick();
    check("t6_busy_later", 32'(bus6.busy_o), 32'd0);
    check("t6_dir", 32'(bus6.dir_o), 32'd0);

    // Asynchronous reset while travelling between 2 and 3.
    do_reset("t7");
    press(1'b1, 6, 1'b0, 0);
    wait_moving_at("t7", 2);
    tick();
    check("t7_pend_pre", 32'(bus8.pending_o), 32'h40);
    rst = 1'b1;
    #1;
    check("t7_async_pend",   32'(bus8.pending_o),   32'h00);
    check("t7_async_floor",  32'(bus8.car_floor_o), 32'd0);
    check("t7_async_moving", 32'(bus8.moving_o),    32'd0);
    check("t7_async_busy",   32'(bus8.busy_o),      32'd0);
    check("t7_async_door",   32'(bus8.door_open_o), 32'd0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("t7_after_moving", 32'(bus8.moving_o),    32'd0);
    check("t7_after_busy",   32'(bus8.busy_o),      32'd0);
    check("t7_after_floor",  32'(bus8.car_floor_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
